button_reader: RTL

- Input-side counterpart to the LED scanner outputs: reads a raw mechanical push-button and turns it into clean, single-cycle events for control logic.
- Typical consumers: speed/direction control of LED effects, mode select.
- Datapath: 2-FF synchronizer, debounce FSM, long-press timer, press counter.
- Sits directly behind a board button pin, in the same 12 MHz clock domain as the LED logic.

---
 rtl/button_reader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/button_reader.sv
// button_reader: 2-FF synchronizer, debounce FSM, long-press timer and press counter for one push-button.
// Define BUTTON_READER_AUTO_REPEAT_EN to add the REPEAT_PULSE auto-repeat output.
module button_reader #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_IN,
    output logic       BTN_LEVEL,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic       LONG_PULSE,
`ifdef BUTTON_READER_AUTO_REPEAT_EN
    output logic       REPEAT_PULSE,
`endif
    output logic [7:0] PRESS_COUNT
);

    localparam int DEB_CYCLES  = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int LONG_CYCLES = (CLK_FREQ / 1000) * LONG_MS;
    localparam int REP_CYCLES  = (CLK_FREQ / 1000) * REPEAT_MS;
    localparam int DEB_W       = $clog2(DEB_CYCLES) + 1;
    localparam int HOLD_W      = $clog2(LONG_CYCLES) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic              REL_RAW   = (ACTIVE_LOW != 0);

    if (DEB_CYCLES < 2 || LONG_CYCLES < 2 || REP_CYCLES < 2) begin : g_param_check
        $error("button_reader: derived cycle counts must be >= 2");
    end

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_DEB,
        S_HELD,
        S_RELEASE_DEB
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               long_done_q, long_done_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;
    logic [7:0]         count_q, count_d;
    logic               btn_s;

`ifdef BUTTON_READER_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REP_CYCLES) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYCLES - 1);

    logic               rep_active_q, rep_active_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               repeat_q, repeat_d;
`endif

    assign btn_s = sync2_q ^ REL_RAW;

    always_comb begin
        sync1_d     = BTN_IN;
        sync2_d     = sync1_q;
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
        rep_active_d = rep_active_q;
        rep_cnt_d    = rep_cnt_q;
        repeat_d     = 1'b0;
`endif

        unique case (state_q)
            S_RELEASED: begin
                if (btn_s) begin
                    state_d   = S_PRESS_DEB;
                    deb_cnt_d = '0;
                end
            end
            S_PRESS_DEB: begin
                if (!btn_s) begin
                    state_d   = S_RELEASED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = S_HELD;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    count_d     = count_q + 8'd1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
                    rep_active_d = 1'b0;
                    rep_cnt_d    = '0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            S_HELD: begin
                // hold_cnt saturates at the long-press threshold; long_done stops a second pulse
                if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
                if (hold_cnt_q == HOLD_LAST && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
                    rep_active_d = 1'b1;
                    rep_cnt_d    = '0;
                end else if (rep_active_q) begin
                    if (rep_cnt_q == REP_LAST) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                        count_d   = count_q + 8'd1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
`endif
                end
                if (!btn_s) begin
                    state_d   = S_RELEASE_DEB;
                    deb_cnt_d = '0;
                end
            end
            S_RELEASE_DEB: begin
                if (btn_s) begin
                    state_d = S_HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = S_RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
                    rep_active_d = 1'b0;
                    rep_cnt_d    = '0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q     <= REL_RAW;
            sync2_q     <= REL_RAW;
            state_q     <= S_RELEASED;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= '0;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
            rep_active_q <= 1'b0;
            rep_cnt_q    <= '0;
            repeat_q     <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            count_q     <= count_d;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
            rep_active_q <= rep_active_d;
            rep_cnt_q    <= rep_cnt_d;
            repeat_q     <= repeat_d;
`endif
        end
    end

    assign BTN_LEVEL     = level_q;
    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = release_q;
    assign LONG_PULSE    = long_q;
    assign PRESS_COUNT   = count_q;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
    assign REPEAT_PULSE  = repeat_q;
`endif

endmodule
